// File: rtl/lpc_pkg.sv
// Shared widths, register map, bit positions and FSM state type for the LPC
// prediction-error filter.
package lpc_pkg;

  localparam int LPC_ORDER     = 10;
  localparam int LPC_DATA_W    = 16;
  localparam int LPC_COEF_W    = 16;
  localparam int LPC_COEF_FRAC = 12;
  localparam int LPC_ACC_W     = 40;

  localparam logic [2:0] REG_COEF_IDX  = 3'd0;
  localparam logic [2:0] REG_COEF_DATA = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_CLEAR     = 3'd4;
  localparam logic [2:0] REG_COUNT     = 3'd5;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_BYPASS_BIT  = 1;
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_OVERRUN_BIT = 1;
  localparam int CLEAR_BIT        = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } lpc_state_e;

endpackage

// File: rtl/lpc_mac.sv
// Serial multiply-accumulate: one signed COEF_W x DATA_W product per cycle
// added into an ACC_W accumulator; clr preloads the accumulator with init.
module lpc_mac
  import lpc_pkg::*;
#(
  parameter int COEF_W = LPC_COEF_W,
  parameter int DATA_W = LPC_DATA_W,
  parameter int ACC_W  = LPC_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [ACC_W-1:0]  init,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;

  // full-precision product, sign-extended to the accumulator width
  always_comb begin
    prod_s     = PROD_W'(a) * PROD_W'(b);
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  // accumulator: preload on clr, accumulate on en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= init;
    end else if (en) begin
      acc <= acc + prod_ext_s;
    end
  end

endmodule

// File: rtl/lpc_error_filter.sv
// Streaming LPC analysis filter e[n] = x[n] - sum a_k*x[n-k] with a serial MAC,
// coefficient bank and Avalon-MM control slave.
module lpc_error_filter
  import lpc_pkg::*;
#(
  parameter int ORDER     = LPC_ORDER,
  parameter int DATA_W    = LPC_DATA_W,
  parameter int COEF_W    = LPC_COEF_W,
  parameter int COEF_FRAC = LPC_COEF_FRAC,
  parameter int ACC_W     = LPC_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     v_in,
  output logic signed [DATA_W-1:0] d_out,
  output logic                     vout,
  input  logic [2:0]               addr,
  input  logic [31:0]              writedata,
  input  logic                     write,
  input  logic                     read,
  output logic [31:0]              readdata
);

  localparam int IDX_W = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic signed [ACC_W-1:0] RND_INIT = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  lpc_state_e               state_r;
  logic [IDX_W-1:0]         k_r;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] hist_r [0:ORDER-1];
  logic signed [COEF_W-1:0] coef_r [0:ORDER-1];
  logic [7:0]               coef_idx_r;
  logic                     enable_r;
  logic                     bypass_r;
  logic                     overrun_r;
  logic [31:0]              count_r;

  logic                     clr_wr_s;
  logic                     accept_s;
  logic                     shift_s;
  logic signed [DATA_W-1:0] hist_in_s;
  logic signed [COEF_W-1:0] mac_a_s;
  logic signed [DATA_W-1:0] mac_b_s;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  pred_s;
  logic signed [ACC_W-1:0]  err_s;
  logic signed [DATA_W-1:0] sat_s;
  logic [31:0]              rd_mux_s;

  // sample acceptance, history shift source and MAC operand select
  always_comb begin
    clr_wr_s  = write && (addr == REG_CLEAR) && writedata[CLEAR_BIT];
    accept_s  = (state_r == IDLE) && enable_r && v_in && !clr_wr_s;
    shift_s   = (state_r == OUT) || (accept_s && bypass_r);
    hist_in_s = (state_r == OUT) ? x_r : d_in;
    mac_a_s   = coef_r[k_r];
    mac_b_s   = hist_r[k_r];
  end

  lpc_mac #(
    .COEF_W (COEF_W),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s && !bypass_r),
    .init (RND_INIT),
    .en   (state_r == MAC),
    .a    (mac_a_s),
    .b    (mac_b_s),
    .acc  (acc_s)
  );

  // rounded prediction, error at accumulator width, saturation to the sample range
  always_comb begin
    pred_s = acc_s >>> COEF_FRAC;
    err_s  = {{(ACC_W-DATA_W){x_r[DATA_W-1]}}, x_r} - pred_s;
    if (err_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_W-1:0];
    end else if (err_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_s = err_s[DATA_W-1:0];
    end
  end

  // sequencing FSM, output register, history, overrun flag and sample count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      k_r       <= '0;
      x_r       <= '0;
      d_out     <= '0;
      vout      <= 1'b0;
      overrun_r <= 1'b0;
      count_r   <= 32'd0;
      for (int i = 0; i < ORDER; i++) hist_r[i] <= '0;
    end else if (clr_wr_s) begin
      // clear aborts any computation and drops a coincident sample silently
      state_r   <= IDLE;
      vout      <= 1'b0;
      overrun_r <= 1'b0;
      count_r   <= 32'd0;
      for (int i = 0; i < ORDER; i++) hist_r[i] <= '0;
    end else begin
      vout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (bypass_r) begin
              d_out <= d_in;
              vout  <= 1'b1;
            end else begin
              x_r     <= d_in;
              k_r     <= '0;
              state_r <= MAC;
            end
          end
        end
        MAC: begin
          k_r <= k_r + IDX_W'(1);
          if (k_r == IDX_W'(ORDER-1)) state_r <= OUT;
        end
        OUT: begin
          d_out   <= sat_s;
          vout    <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      if (shift_s) begin
        hist_r[0] <= hist_in_s;
        for (int i = 1; i < ORDER; i++) hist_r[i] <= hist_r[i-1];
        count_r <= count_r + 32'd1;
      end
      if ((state_r != IDLE) && v_in) overrun_r <= 1'b1;
    end
  end

  // coefficient bank and control writes; bank is locked while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_idx_r <= 8'd0;
      enable_r   <= 1'b0;
      bypass_r   <= 1'b0;
      for (int i = 0; i < ORDER; i++) coef_r[i] <= '0;
    end else if (write) begin
      case (addr)
        REG_COEF_IDX: begin
          if (!enable_r) coef_idx_r <= (|writedata[31:8]) ? 8'hFF : writedata[7:0];
        end
        REG_COEF_DATA: begin
          if (!enable_r && (coef_idx_r < 8'(ORDER))) begin
            coef_r[coef_idx_r[IDX_W-1:0]] <= writedata[COEF_W-1:0];
            coef_idx_r <= coef_idx_r + 8'd1;
          end
        end
        REG_CTRL: begin
          enable_r <= writedata[CTRL_ENABLE_BIT];
          bypass_r <= writedata[CTRL_BYPASS_BIT];
        end
        default: ;
      endcase
    end
  end

  // read-data mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr)
      REG_CTRL: begin
        rd_mux_s[CTRL_ENABLE_BIT] = enable_r;
        rd_mux_s[CTRL_BYPASS_BIT] = bypass_r;
      end
      REG_STATUS: begin
        rd_mux_s[STAT_BUSY_BIT]    = (state_r != IDLE);
        rd_mux_s[STAT_OVERRUN_BIT] = overrun_r;
      end
      REG_COUNT: rd_mux_s = count_r;
      default:   rd_mux_s = 32'd0;
    endcase
  end

  // registered read data, valid the cycle after read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readdata <= 32'd0;
    end else if (read) begin
      readdata <= rd_mux_s;
    end else begin
      readdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_lpc_error_filter.sv
// Scoreboard bench for lpc_error_filter: a behavioural model predicts each
// output and its arrival cycle; a monitor compares whenever vout pulses.
module tb_lpc_error_filter;

  localparam int ORDER     = 10;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 12;
  localparam int ACC_W     = 40;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic signed [DATA_W-1:0] d_in = '0;
  logic                     v_in = 1'b0;
  logic signed [DATA_W-1:0] d_out;
  logic                     vout;
  logic [2:0]               addr = 3'd0;
  logic [31:0]              writedata = 32'd0;
  logic                     write = 1'b0;
  logic                     read = 1'b0;
  logic [31:0]              readdata;

  lpc_error_filter #(
    .ORDER(ORDER), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .v_in(v_in), .d_out(d_out), .vout(vout),
    .addr(addr), .writedata(writedata), .write(write), .read(read), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; int due; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int          ref_coef [ORDER];
  int          ref_hist [ORDER];
  bit          ref_en, ref_byp, ref_ovr;
  int          ref_idx;
  int          ref_free;
  logic [31:0] ref_count;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ORDER; i++) begin ref_coef[i] = 0; ref_hist[i] = 0; end
    ref_en = 0; ref_byp = 0; ref_ovr = 0; ref_idx = 0; ref_free = 0; ref_count = 0;
    sb_q.delete();
  endtask

  // prediction error from the textbook formula with floor rounding
  function automatic int ref_err(input int x);
    longint s, num, p, e;
    s = 0;
    for (int k = 0; k < ORDER; k++) s += longint'(ref_coef[k]) * longint'(ref_hist[k]);
    num = s + (longint'(1) << (COEF_FRAC - 1));
    p = num / (longint'(1) << COEF_FRAC);
    if ((num % (longint'(1) << COEF_FRAC)) != 0 && num < 0) p = p - 1;
    e = longint'(x) - p;
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
    return int'(e);
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: if (!ref_en) ref_idx = (d[31:8] != 24'd0) ? 255 : int'(d[7:0]);
      3'd1: if (!ref_en && ref_idx < ORDER) begin
              ref_coef[ref_idx] = int'($signed(d[15:0]));
              ref_idx++;
            end
      3'd2: begin ref_en = d[0]; ref_byp = d[1]; end
      3'd4: if (d[0]) begin
              for (int i = 0; i < ORDER; i++) ref_hist[i] = 0;
              ref_ovr = 0; ref_count = 0; ref_free = 0;
            end
      default: ;
    endcase
  endtask

  task automatic model_sample(input int x);
    exp_t e;
    if (ref_en) begin
      if (cyc < ref_free) begin
        ref_ovr = 1;
      end else begin
        e.data = ref_byp ? x : ref_err(x);
        e.due  = cyc + (ref_byp ? 1 : ORDER + 2);
        sb_q.push_back(e);
        ref_free = e.due;
        for (int i = ORDER - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
        ref_hist[0] = x;
        ref_count++;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; writedata = d; write = 1'b1;
    model_write(a, d);
    tick(1);
    write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output int rd);
    addr = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    rd = int'(readdata);
  endtask

  task automatic send(input int x);
    d_in = DATA_W'(x); v_in = 1'b1;
    model_sample(x);
    tick(1);
    v_in = 1'b0;
  endtask

  task automatic send_gap(input int x, input int gap);
    send(x);
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 40) begin tick(1); t++; end
    check(name, sb_q.size(), 0);
    tick(3);
  endtask

  task automatic check_regs(input string tag);
    int rd;
    reg_read(3'd3, rd);
    check({tag, "_status"}, rd, {30'd0, ref_ovr, 1'b0});
    reg_read(3'd5, rd);
    check({tag, "_count"}, rd, int'(ref_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int rd;
    exp_t e;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (rst && vout) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_vout: got d_out=%0d, expected no output (cycle %0d)", d_out, cyc);
          end else begin
            e = sb_q.pop_front();
            check("vout_data", int'(d_out), e.data);
            check("vout_cycle", cyc, e.due);
          end
        end
      end
    join_none

    tick(3);
    check("rst_d_out", int'(d_out), 0);
    check("rst_vout", int'(vout), 0);
    rst = 1'b1;
    tick(1);
    reg_read(3'd2, rd); check("rst_ctrl", rd, 0);
    check_regs("rst");

    // zero coefficients: pass-through with ORDER+2 latency
    reg_write(3'd2, 32'd1);
    send_gap(100, 20);
    send_gap(-200, 20);
    drain("t1_drain");
    check_regs("t1");

    // first-order predictor a1 = 1.0
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'd0);
    reg_write(3'd1, 32'd4096);
    reg_write(3'd4, 32'd1);
    reg_write(3'd2, 32'd1);
    send_gap(1000, ORDER + 2);
    send_gap(1500, ORDER + 2);
    send_gap(1200, ORDER + 2);
    drain("t2_drain");

    // saturation with a1 = -1.0
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'd0);
    reg_write(3'd1, 32'hFFFF_F000);
    reg_write(3'd4, 32'd1);
    reg_write(3'd2, 32'd1);
    send_gap(30000, ORDER + 2);
    send_gap(30000, ORDER + 2);
    drain("t3a_drain");
    reg_write(3'd4, 32'd1);
    send_gap(-30000, ORDER + 2);
    send_gap(-30000, ORDER + 2);
    drain("t3b_drain");

    // overrun, clear, and clear coinciding with a sample
    reg_write(3'd4, 32'd1);
    send_gap(500, 5);
    send(600);
    drain("t4_drain");
    check_regs("t4_ovr");
    reg_write(3'd4, 32'd1);
    check_regs("t4_clr");
    addr = 3'd4; writedata = 32'd1; write = 1'b1; d_in = 16'sd321; v_in = 1'b1;
    model_write(3'd4, 32'd1);
    tick(1);
    write = 1'b0; v_in = 1'b0;
    tick(15);
    check_regs("t4_clrv");
    send_gap(700, ORDER + 2);
    drain("t4b_drain");

    // bypass, then coefficient writes while enabled must be ignored
    reg_write(3'd2, 32'd3);
    send_gap(1234, 4);
    drain("t5a_drain");
    reg_write(3'd0, 32'd0);
    reg_write(3'd1, 32'd0);
    reg_write(3'd2, 32'd1);
    send_gap(1000, ORDER + 2);
    send_gap(1000, ORDER + 2);
    drain("t5b_drain");
    check_regs("t5");

    // randomized coefficients, samples, spacing and bypass
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'd0);
    reg_write(3'd1, 32'($urandom_range(2048, 4096)));
    for (int i = 1; i < ORDER; i++) reg_write(3'd1, 32'(int'($urandom_range(0, 4096)) - 2048));
    reg_write(3'd1, 32'd777);
    reg_write(3'd0, 32'd300);
    reg_write(3'd1, 32'd999);
    reg_write(3'd4, 32'd1);
    reg_write(3'd2, 32'd1);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) reg_write(3'd2, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
      send_gap(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(4, 16)));
    end
    drain("t6_drain");
    check_regs("t6");

    // asynchronous reset in the middle of a MAC run
    reg_write(3'd2, 32'd1);
    send(555);
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(2);
    check("t7_d_out", int'(d_out), 0);
    check("t7_vout", int'(vout), 0);
    rst = 1'b1;
    tick(1);
    reg_read(3'd2, rd); check("t7_ctrl", rd, 0);
    check_regs("t7");
    reg_write(3'd2, 32'd1);
    send_gap(77, ORDER + 2);
    send_gap(77, ORDER + 2);
    drain("t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
